// File: rtl/mac_operand_sequencer.sv
// Operand-pair FIFO feeding the MMIO MAC: buffers (x,y) pairs and streams a
// commanded number of them into the MAC's ready/valid port, pulsing done when finished.
module mac_operand_sequencer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int LENW  = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_x,
   input  logic [WIDTH-1:0]         in_y,
   input  logic                     flush,
   input  logic                     start,
   input  logic [LENW-1:0]          len,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_x,
   output logic [WIDTH-1:0]         out_y,
   input  logic                     mac_busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [WIDTH-1:0] mem_x_q [DEPTH];
   logic [WIDTH-1:0] mem_y_q [DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [1:0]      state_q, state_d;
   logic [LENW-1:0] remaining_q, remaining_d;
   logic            guard_q, guard_d;
   logic            done_q, done_d;

   logic full, empty, push, pop;

   always_comb begin
      full      = (count_q == FULL_CNT);
      empty     = (count_q == '0);
      in_ready  = !full;
      out_valid = (state_q == S_ISSUE) && !empty;
      // flush wins over both FIFO ports, so neither side moves in that cycle
      push      = in_valid && in_ready && !flush;
      pop       = out_valid && out_ready && !flush;
      out_x     = mem_x_q[rd_ptr_q];
      out_y     = mem_y_q[rd_ptr_q];
      busy      = (state_q != S_IDLE);
      done      = done_q;
      count     = count_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      guard_d     = guard_q;
      done_d      = 1'b0;
      if (flush) begin
         state_d     = S_IDLE;
         remaining_d = '0;
         guard_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state_d     = S_ISSUE;
                     remaining_d = len;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (pop) begin
                  remaining_d = remaining_q - LENW'(1);
                  if (remaining_q == LENW'(1)) begin
                     state_d = S_WAIT;
                     guard_d = 1'b1;
                  end
               end
            end
            S_WAIT: begin
               // MAC raises busy a cycle after its handshake, so skip the first cycle
               guard_d = 1'b0;
               if (!guard_q && !mac_busy) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         remaining_q <= '0;
         guard_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
         guard_q     <= guard_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_x_q[wr_ptr_q] <= in_x;
         mem_y_q[wr_ptr_q] <= in_y;
      end
   end

endmodule
